// File: rtl/seg_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : seg_pipe_adder
// Description : Segmented pipelined adder/subtractor. One SEG-bit ripple
//               segment per stage, carry registered between stages, with
//               valid/ready flow control and signed-overflow reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;

    // r_x carries finished sum bits below the current segment and untouched
    // A bits above it; r_y carries the full effective B operand.
    logic [WIDTH-1:0]  r_x [STAGES];
    logic [WIDTH-1:0]  r_y [STAGES];
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] r_v;
    logic              r_cmsb;

    logic [WIDTH-1:0]  w_x_in  [STAGES];
    logic [WIDTH-1:0]  w_y_in  [STAGES];
    logic [WIDTH-1:0]  w_x_out [STAGES];
    logic [SEG:0]      w_seg   [STAGES];
    logic [STAGES-1:0] w_c_in;
    logic [STAGES-1:0] w_c_out;
    logic              w_cmsb;
    logic              w_adv;

    always_comb begin
        w_c_in    = '0;
        w_c_out   = '0;
        w_x_in[0] = a;
        w_y_in[0] = sub ? ~b : b;
        w_c_in[0] = ci ^ sub;
        for (int k = 1; k < STAGES; k++) begin
            w_x_in[k] = r_x[k-1];
            w_y_in[k] = r_y[k-1];
            w_c_in[k] = r_c[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_seg[k] = {1'b0, w_x_in[k][k*SEG +: SEG]}
                     + {1'b0, w_y_in[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, w_c_in[k]};
            w_x_out[k]                 = w_x_in[k];
            w_x_out[k][k*SEG +: SEG]   = w_seg[k][SEG-1:0];
            w_c_out[k]                 = w_seg[k][SEG];
        end
        // Carry into the MSB recovered from the MSB's own sum equation.
        w_cmsb = w_x_in[STAGES-1][WIDTH-1] ^ w_y_in[STAGES-1][WIDTH-1]
               ^ w_x_out[STAGES-1][WIDTH-1];
    end

    assign w_adv = ~r_v[STAGES-1] | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_x[k] <= '0;
                r_y[k] <= '0;
            end
            r_c    <= '0;
            r_v    <= '0;
            r_cmsb <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_x[k] <= w_x_out[k];
                r_y[k] <= w_y_in[k];
            end
            r_v[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                r_v[k] <= r_v[k-1];
            end
            r_c    <= w_c_out;
            r_cmsb <= w_cmsb;
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_v[STAGES-1];
    assign s         = r_x[STAGES-1];
    assign co        = r_c[STAGES-1];
    assign ovf       = r_c[STAGES-1] ^ r_cmsb;

endmodule
`default_nettype wire

// File: tb/tb_seg_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_pipe_adder
// Description : Self-checking bench for seg_pipe_adder at three parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_pipe_adder;

    typedef struct {
        logic [15:0] a, b;
        logic        ci, sub;
        logic [15:0] s;
        logic        co, ovf;
    } vec_t;

    typedef struct {
        logic [17:0] exp;
        int          cyc;
        bit          lat;
    } sb_t;

    logic clk, rst_n;

    logic        in_valid16, in_ready16, ci16, sub16, out_valid16, out_ready16, co16, ovf16;
    logic [15:0] a16, b16, s16;
    logic [17:0] exp16;

    logic        in_valid4, in_ready4, ci4, sub4, out_valid4, out_ready4, co4, ovf4;
    logic [3:0]  a4, b4, s4;

    logic        in_valid8, in_ready8, ci8, sub8, out_valid8, out_ready8, co8, ovf8;
    logic [7:0]  a8, b8, s8;

    int  errors = 0;
    int  checks = 0;
    int  cyc    = 0;
    bit  lat_mode = 1;
    bit  bp_mode  = 0;
    sb_t q16[$], q4[$], q8[$];
    vec_t tbl [8];

    seg_pipe_adder #(.WIDTH(16), .SEG(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .ci(ci16), .sub(sub16), .out_valid(out_valid16),
        .out_ready(out_ready16), .s(s16), .co(co16), .ovf(ovf16));

    seg_pipe_adder #(.WIDTH(4), .SEG(1)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .ci(ci4), .sub(sub4), .out_valid(out_valid4),
        .out_ready(out_ready4), .s(s4), .co(co4), .ovf(ovf4));

    seg_pipe_adder #(.WIDTH(8), .SEG(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .ci(ci8), .sub(sub8), .out_valid(out_valid8),
        .out_ready(out_ready8), .s(s8), .co(co8), .ovf(ovf8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic, returns {ovf, co, s}.
    function automatic logic [17:0] model(input int w, input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mci, input logic msub);
        int mask, hm, bb, c0, full, low;
        logic co_b, cm;
        mask = (1 << w) - 1;
        hm   = (1 << (w - 1)) - 1;
        bb   = msub ? (int'(~mb) & mask) : (int'(mb) & mask);
        c0   = (mci ^ msub) ? 1 : 0;
        full = (int'(ma) & mask) + bb + c0;
        low  = (int'(ma) & hm) + (bb & hm) + c0;
        co_b = ((full >> w) & 1) != 0;
        cm   = ((low >> (w - 1)) & 1) != 0;
        return {co_b ^ cm, co_b, 16'(full & mask)};
    endfunction

    task automatic send16(input logic [15:0] ia, input logic [15:0] ib, input logic ici,
                          input logic isub, input logic [17:0] iexp);
        a16 = ia; b16 = ib; ci16 = ici; sub16 = isub; exp16 = iexp; in_valid16 = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready16) begin
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        check("accept16_timeout", 0, 1);
    endtask

    task automatic send4(input logic [3:0] ia, input logic [3:0] ib, input logic ici, input logic isub);
        a4 = ia; b4 = ib; ci4 = ici; sub4 = isub; in_valid4 = 1'b1;
        @(negedge clk);
        check("ready4", in_ready4, 1);
        @(posedge clk); #1;
    endtask

    task automatic send8(input logic [7:0] ia, input logic [7:0] ib, input logic ici, input logic isub);
        a8 = ia; b8 = ib; ci8 = ici; sub8 = isub; in_valid8 = 1'b1;
        @(negedge clk);
        check("ready8", in_ready8, 1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && (q16.size() != 0 || q4.size() != 0 || q8.size() != 0); t++)
            @(negedge clk);
        check("drain16", q16.size(), 0);
        check("drain4", q4.size(), 0);
        check("drain8", q8.size(), 0);
        @(posedge clk); #1;
    endtask

    // Random backpressure on the 16-bit instance, ~30% low.
    initial forever begin
        @(posedge clk); #1;
        if (bp_mode) out_ready16 = ($urandom_range(0, 9) >= 3);
    end

    // Scoreboard / monitor, sampling on the falling edge.
    logic        stall16 = 1'b0;
    logic [17:0] prev16;
    initial forever begin
        sb_t e;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            stall16 = 1'b0;
        end else begin
            check("in_ready16", in_ready16, !out_valid16 || out_ready16);
            if (stall16) check("stall16", {out_valid16, ovf16, co16, s16}, {1'b1, prev16});
            if (out_valid16 && out_ready16) begin
                if (q16.size() == 0) check("spurious16", 1, 0);
                else begin
                    e = q16.pop_front();
                    check("result16", {ovf16, co16, s16}, e.exp);
                    if (e.lat) check("latency16", cyc - e.cyc, 4);
                end
            end
            if (in_valid16 && in_ready16) q16.push_back('{exp16, cyc, lat_mode});
            stall16 = out_valid16 && !out_ready16;
            prev16  = {ovf16, co16, s16};

            if (out_valid4 && out_ready4) begin
                if (q4.size() == 0) check("spurious4", 1, 0);
                else begin
                    e = q4.pop_front();
                    check("result4", {ovf4, co4, 12'h000, s4}, e.exp);
                    if (e.lat) check("latency4", cyc - e.cyc, 4);
                end
            end
            if (in_valid4 && in_ready4)
                q4.push_back('{model(4, {12'h000, a4}, {12'h000, b4}, ci4, sub4), cyc, lat_mode});

            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) check("spurious8", 1, 0);
                else begin
                    e = q8.pop_front();
                    check("result8", {ovf8, co8, 8'h00, s8}, e.exp);
                    if (e.lat) check("latency8", cyc - e.cyc, 1);
                end
            end
            if (in_valid8 && in_ready8)
                q8.push_back('{model(8, {8'h00, a8}, {8'h00, b8}, ci8, sub8), cyc, lat_mode});
        end
    end

    initial begin
        bit got;
        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
        tbl[6] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tbl[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst_n = 1'b1;
        in_valid16 = 0; a16 = 0; b16 = 0; ci16 = 0; sub16 = 0; exp16 = 0; out_ready16 = 1;
        in_valid4 = 0; a4 = 0; b4 = 0; ci4 = 0; sub4 = 0; out_ready4 = 1;
        in_valid8 = 0; a8 = 0; b8 = 0; ci8 = 0; sub8 = 0; out_ready8 = 1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid16", out_valid16, 0);
        check("rst_in_ready16", in_ready16, 1);
        check("rst_result16", {ovf16, co16, s16}, 0);
        check("rst_out_valid4", out_valid4, 0);
        check("rst_out_valid8", out_valid8, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single carry-propagating op: latency and one-cycle valid pulse.
        send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        in_valid16 = 1'b0;
        got = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid16) begin got = 1; break; end
        end
        check("seen16", got, 1);
        @(negedge clk);
        check("pulse16", out_valid16, 0);
        @(posedge clk); #1;

        // Directed table, back to back.
        for (int i = 0; i < 8; i++)
            send16(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sub, {tbl[i].ovf, tbl[i].co, tbl[i].s});
        in_valid16 = 1'b0;
        drain();

        // Streaming with random backpressure.
        lat_mode = 0;
        bp_mode  = 1;
        for (int i = 0; i < 20; i++) begin
            logic [15:0] ra, rb;
            logic rc, rs;
            ra = 16'($urandom()); rb = 16'($urandom());
            rc = 1'($urandom()); rs = 1'($urandom());
            send16(ra, rb, rc, rs, model(16, ra, rb, rc, rs));
        end
        in_valid16 = 1'b0;
        bp_mode = 0;
        out_ready16 = 1'b1;
        drain();

        // Reset with three operations in flight.
        lat_mode = 1;
        send16(16'h1111, 16'h2222, 1'b0, 1'b0, model(16, 16'h1111, 16'h2222, 1'b0, 1'b0));
        send16(16'hAAAA, 16'h5555, 1'b1, 1'b0, model(16, 16'hAAAA, 16'h5555, 1'b1, 1'b0));
        send16(16'h0F0F, 16'h00FF, 1'b0, 1'b1, model(16, 16'h0F0F, 16'h00FF, 1'b0, 1'b1));
        in_valid16 = 1'b0;
        @(posedge clk); #1;
        check("prereset_valid16", out_valid16, 1);
        #1 rst_n = 1'b0;
        #1;
        check("reset_valid16", out_valid16, 0);
        check("reset_result16", {ovf16, co16, s16}, 0);
        check("reset_in_ready16", in_ready16, 1);
        q16.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send16(16'h4000, 16'h4000, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
        in_valid16 = 1'b0;
        drain();

        // WIDTH=4, SEG=1 exhaustive.
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    for (int is = 0; is < 2; is++)
                        send4(4'(ia), 4'(ib), 1'(ic), 1'(is));
        in_valid4 = 1'b0;

        // WIDTH=8, SEG=8 random.
        for (int i = 0; i < 100; i++)
            send8(8'($urandom()), 8'($urandom()), 1'($urandom()), 1'($urandom()));
        in_valid8 = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
